// File: rtl/mem_arbiter.sv
// Three-way memory port arbiter in the clock28 domain.
// Video has fixed top priority; the CPU outranks the loader, but a starvation
// counter forces a loader grant after STARVE consecutive CPU grants made while
// the loader was waiting. Every transaction walks IDLE -> BUSY -> DONE, so the
// requester sees its ack and drops its request before the next arbitration.
module mem_arbiter #(
   parameter int AW     = 18,
   parameter int DW     = 8,
   parameter int STARVE = 4
) (
   input  logic          clock,
   input  logic          reset,
   // video fetch (read-only)
   input  logic          vReq,
   input  logic [AW-1:0] vA,
   output logic [DW-1:0] vQ,
   output logic          vAck,
   // CPU
   input  logic          cReq,
   input  logic          cWr,
   input  logic [AW-1:0] cA,
   input  logic [DW-1:0] cD,
   output logic [DW-1:0] cQ,
   output logic          cAck,
   // ROM/image loader (write-only)
   input  logic          lReq,
   input  logic [AW-1:0] lA,
   input  logic [DW-1:0] lD,
   output logic          lAck,
   // memory controller port
   output logic          mReq,
   output logic          mWr,
   output logic [AW-1:0] mA,
   output logic [DW-1:0] mD,
   input  logic [DW-1:0] mQ,
   input  logic          mRdy,
   // current owner
   output logic [1:0]    own
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_CPU, OWN_LDR} owner_t;

   localparam logic [3:0] STARVE_L = 4'(STARVE);

   state_t        state, state_nx;
   owner_t        own_r, own_nx;
   logic          mReq_nx, mWr_nx;
   logic [AW-1:0] mA_nx;
   logic [DW-1:0] mD_nx, vQ_nx, cQ_nx;
   logic          vAck_nx, cAck_nx, lAck_nx;
   logic [3:0]    cnt, cnt_nx;

   assign own = own_r;

   // FSM state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Registered memory-port, read-data, ack, owner and starvation-count state
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         own_r <= OWN_NONE;
         mReq  <= 1'b0;
         mWr   <= 1'b0;
         mA    <= '0;
         mD    <= '0;
         vQ    <= '0;
         cQ    <= '0;
         vAck  <= 1'b0;
         cAck  <= 1'b0;
         lAck  <= 1'b0;
         cnt   <= '0;
      end else begin
         own_r <= own_nx;
         mReq  <= mReq_nx;
         mWr   <= mWr_nx;
         mA    <= mA_nx;
         mD    <= mD_nx;
         vQ    <= vQ_nx;
         cQ    <= cQ_nx;
         vAck  <= vAck_nx;
         cAck  <= cAck_nx;
         lAck  <= lAck_nx;
         cnt   <= cnt_nx;
      end
   end

   // Arbitration, transaction sequencing and next-value computation
   always_comb begin
      state_nx = state;
      own_nx   = own_r;
      mReq_nx  = mReq;
      mWr_nx   = mWr;
      mA_nx    = mA;
      mD_nx    = mD;
      vQ_nx    = vQ;
      cQ_nx    = cQ;
      vAck_nx  = 1'b0;
      cAck_nx  = 1'b0;
      lAck_nx  = 1'b0;
      cnt_nx   = cnt;

      case (state)
         IDLE: begin
            if (vReq) begin
               own_nx   = OWN_VID;
               mA_nx    = vA;
               mD_nx    = '0;
               mWr_nx   = 1'b0;
               mReq_nx  = 1'b1;
               state_nx = BUSY;
            end else if (cReq && !(lReq && cnt == STARVE_L)) begin
               own_nx   = OWN_CPU;
               mA_nx    = cA;
               mD_nx    = cD;
               mWr_nx   = cWr;
               mReq_nx  = 1'b1;
               state_nx = BUSY;
               // A CPU grant with the loader waiting implies cnt < STARVE,
               // so the increment saturates at STARVE by construction.
               if (lReq) cnt_nx = cnt + 4'd1;
            end else if (lReq) begin
               own_nx   = OWN_LDR;
               mA_nx    = lA;
               mD_nx    = lD;
               mWr_nx   = 1'b1;
               mReq_nx  = 1'b1;
               state_nx = BUSY;
               cnt_nx   = '0;
            end
         end
         BUSY: begin
            if (mRdy) begin
               mReq_nx  = 1'b0;
               mWr_nx   = 1'b0;
               own_nx   = OWN_NONE;
               state_nx = DONE;
               case (own_r)
                  OWN_VID: begin
                     vAck_nx = 1'b1;
                     if (!mWr) vQ_nx = mQ;
                  end
                  OWN_CPU: begin
                     cAck_nx = 1'b1;
                     if (!mWr) cQ_nx = mQ;
                  end
                  OWN_LDR: lAck_nx = 1'b1;
                  default: ;
               endcase
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase

      if (!lReq) cnt_nx = '0;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of single-requester transactions
// followed by hand-written multi-cycle sequences (simultaneous requests,
// starvation, video pre-emption, abort, stray mRdy, async reset).
module tb_mem_arbiter;

   localparam int AW = 18;
   localparam int DW = 8;

   localparam logic [1:0] O_NONE = 2'd0;
   localparam logic [1:0] O_VID  = 2'd1;
   localparam logic [1:0] O_CPU  = 2'd2;
   localparam logic [1:0] O_LDR  = 2'd3;

   logic          clock = 1'b0;
   logic          reset;
   logic          vReq, cReq, cWr, lReq, mRdy;
   logic [AW-1:0] vA, cA, lA, mA;
   logic [DW-1:0] cD, lD, mQ, vQ, cQ, mD;
   logic          vAck, cAck, lAck, mReq, mWr;
   logic [1:0]    own;

   int total = 0;
   int bad   = 0;

   mem_arbiter #(.AW(AW), .DW(DW), .STARVE(4)) dut (
      .clock(clock), .reset(reset),
      .vReq(vReq), .vA(vA), .vQ(vQ), .vAck(vAck),
      .cReq(cReq), .cWr(cWr), .cA(cA), .cD(cD), .cQ(cQ), .cAck(cAck),
      .lReq(lReq), .lA(lA), .lD(lD), .lAck(lAck),
      .mReq(mReq), .mWr(mWr), .mA(mA), .mD(mD), .mQ(mQ), .mRdy(mRdy),
      .own(own)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [1:0]    own;
      logic          wr;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [DW-1:0] q;
      int            dly;
      logic [DW-1:0] vq;
      logic [DW-1:0] cq;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [2:0] ack_for(input logic [1:0] o);
      case (o)
         O_VID:   return 3'b100;
         O_CPU:   return 3'b010;
         O_LDR:   return 3'b001;
         default: return 3'b000;
      endcase
   endfunction

   // Waits (bounded) for mReq and checks the granted transaction.
   task automatic wait_grant(input string tag, input logic [1:0] eo, input logic [AW-1:0] ea,
                             input logic ew, input logic [DW-1:0] ed, output int waited);
      waited = 0;
      while (!mReq && waited < 20) begin
         tick();
         waited++;
      end
      check({tag, " mReq"}, 32'(mReq), 32'd1);
      check({tag, " own"},  32'(own),  32'(eo));
      check({tag, " mA"},   32'(mA),   32'(ea));
      check({tag, " mWr"},  32'(mWr),  32'(ew));
      if (ew) check({tag, " mD"}, 32'(mD), 32'(ed));
   endtask

   // Returns mRdy after dly cycles, checks the single ack pulse.
   task automatic complete(input string tag, input logic [1:0] eo, input int dly,
                           input logic [DW-1:0] qv, input logic drop);
      repeat (dly) tick();
      mRdy = 1'b1;
      mQ   = qv;
      tick();
      mRdy = 1'b0;
      mQ   = 8'hEE;
      check({tag, " ack"},      32'({vAck, cAck, lAck}), 32'(ack_for(eo)));
      check({tag, " own done"}, 32'(own),  32'(O_NONE));
      check({tag, " mReq done"}, 32'(mReq), 32'd0);
      if (drop) begin
         case (eo)
            O_VID:   vReq = 1'b0;
            O_CPU:   cReq = 1'b0;
            O_LDR:   lReq = 1'b0;
            default: ;
         endcase
      end
      tick();
      check({tag, " ack clear"}, 32'({vAck, cAck, lAck}), 32'd0);
      check({tag, " no grant in done"}, 32'(mReq), 32'd0);
   endtask

   task automatic serve(input string tag, input logic [1:0] eo, input logic [AW-1:0] ea,
                        input logic ew, input logic [DW-1:0] ed, input int dly,
                        input logic [DW-1:0] qv, input logic drop);
      int w;
      wait_grant(tag, eo, ea, ew, ed, w);
      check({tag, " latency"}, 32'(w), 32'd1);
      complete(tag, eo, dly, qv, drop);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      vecs[0] = '{own: O_CPU, wr: 1'b0, a: 18'h04000, d: 8'h00, q: 8'hA5, dly: 2, vq: 8'h00, cq: 8'hA5};
      vecs[1] = '{own: O_CPU, wr: 1'b1, a: 18'h1ABCD, d: 8'h5A, q: 8'h11, dly: 1, vq: 8'h00, cq: 8'hA5};
      vecs[2] = '{own: O_VID, wr: 1'b0, a: 18'h3FFFF, d: 8'h00, q: 8'h77, dly: 0, vq: 8'h77, cq: 8'hA5};
      vecs[3] = '{own: O_LDR, wr: 1'b1, a: 18'h00010, d: 8'h3C, q: 8'h99, dly: 1, vq: 8'h77, cq: 8'hA5};
      vecs[4] = '{own: O_CPU, wr: 1'b0, a: 18'h00000, d: 8'h00, q: 8'h3C, dly: 0, vq: 8'h77, cq: 8'h3C};
      vecs[5] = '{own: O_VID, wr: 1'b0, a: 18'h20001, d: 8'h00, q: 8'hC3, dly: 3, vq: 8'hC3, cq: 8'h3C};

      reset = 1'b1;
      vReq = 1'b0; cReq = 1'b0; lReq = 1'b0; cWr = 1'b0; mRdy = 1'b0;
      vA = '0; cA = '0; lA = '0; cD = '0; lD = '0; mQ = '0;
      tick();
      tick();
      check("reset mReq", 32'(mReq), 32'd0);
      check("reset mWr",  32'(mWr),  32'd0);
      check("reset own",  32'(own),  32'd0);
      check("reset acks", 32'({vAck, cAck, lAck}), 32'd0);
      check("reset mA",   32'(mA),   32'd0);
      check("reset mD",   32'(mD),   32'd0);
      check("reset vQ",   32'(vQ),   32'd0);
      check("reset cQ",   32'(cQ),   32'd0);
      reset = 1'b0;
      tick();

      // Table of single-requester transactions
      for (int i = 0; i < 6; i++) begin
         vReq = (vecs[i].own == O_VID);
         cReq = (vecs[i].own == O_CPU);
         lReq = (vecs[i].own == O_LDR);
         vA   = (vecs[i].own == O_VID) ? vecs[i].a : ~vecs[i].a;
         cA   = (vecs[i].own == O_CPU) ? vecs[i].a : ~vecs[i].a;
         lA   = (vecs[i].own == O_LDR) ? vecs[i].a : ~vecs[i].a;
         cD   = (vecs[i].own == O_CPU) ? vecs[i].d : ~vecs[i].d;
         lD   = (vecs[i].own == O_LDR) ? vecs[i].d : ~vecs[i].d;
         cWr  = (vecs[i].own == O_CPU) ? vecs[i].wr : 1'b1;
         serve($sformatf("vec%0d", i), vecs[i].own, vecs[i].a,
               (vecs[i].own == O_CPU) ? vecs[i].wr : (vecs[i].own == O_LDR),
               vecs[i].d, vecs[i].dly, vecs[i].q, 1'b1);
         check($sformatf("vec%0d vQ", i), 32'(vQ), 32'(vecs[i].vq));
         check($sformatf("vec%0d cQ", i), 32'(cQ), 32'(vecs[i].cq));
      end

      // Simultaneous requests: video, then cpu, then loader
      vReq = 1'b1; vA = 18'h11111;
      cReq = 1'b1; cA = 18'h22222; cWr = 1'b0; cD = 8'h44;
      lReq = 1'b1; lA = 18'h33333; lD = 8'h96;
      serve("simul vid", O_VID, 18'h11111, 1'b0, 8'h00, 0, 8'h12, 1'b1);
      serve("simul cpu", O_CPU, 18'h22222, 1'b0, 8'h00, 1, 8'h34, 1'b1);
      serve("simul ldr", O_LDR, 18'h33333, 1'b1, 8'h96, 0, 8'h56, 1'b1);
      check("simul vQ", 32'(vQ), 32'h12);
      check("simul cQ", 32'(cQ), 32'h34);

      // Starvation: four CPU grants then one loader grant, twice
      cReq = 1'b1; cA = 18'h00200; cWr = 1'b0;
      lReq = 1'b1; lA = 18'h00010; lD = 8'h3C;
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 4; k++)
            serve($sformatf("starve r%0d cpu%0d", r, k), O_CPU, 18'h00200, 1'b0, 8'h00, 0, 8'(k), 1'b0);
         serve($sformatf("starve r%0d ldr", r), O_LDR, 18'h00010, 1'b1, 8'h3C, 0, 8'hFF, 1'b0);
      end
      cReq = 1'b0;
      lReq = 1'b0;
      tick();

      // Video arrives during a CPU transaction and jumps the pending loader
      cReq = 1'b1; cA = 18'h00300; cWr = 1'b0;
      lReq = 1'b1; lA = 18'h00020; lD = 8'h81;
      wait_grant("preempt cpu0", O_CPU, 18'h00300, 1'b0, 8'h00, w);
      vReq = 1'b1; vA = 18'h12345;
      complete("preempt cpu0", O_CPU, 1, 8'h21, 1'b0);
      serve("preempt vid", O_VID, 18'h12345, 1'b0, 8'h00, 0, 8'h5D, 1'b1);
      for (int k = 1; k < 4; k++)
         serve($sformatf("preempt cpu%0d", k), O_CPU, 18'h00300, 1'b0, 8'h00, 0, 8'h22, 1'b0);
      serve("preempt ldr", O_LDR, 18'h00020, 1'b1, 8'h81, 0, 8'h00, 1'b0);
      check("preempt vQ", 32'(vQ), 32'h5D);
      cReq = 1'b0;
      lReq = 1'b0;
      tick();

      // Requester abort: request dropped in BUSY still completes
      cReq = 1'b1; cA = 18'h00400; cWr = 1'b0;
      wait_grant("abort", O_CPU, 18'h00400, 1'b0, 8'h00, w);
      cReq = 1'b0;
      complete("abort", O_CPU, 3, 8'h5E, 1'b0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("abort idle%0d mReq", k), 32'(mReq), 32'd0);
      end
      check("abort cQ", 32'(cQ), 32'h5E);

      // Stray mRdy in IDLE is ignored
      mRdy = 1'b1; mQ = 8'hFF;
      tick();
      tick();
      mRdy = 1'b0;
      check("stray acks", 32'({vAck, cAck, lAck}), 32'd0);
      check("stray mReq", 32'(mReq), 32'd0);
      check("stray cQ",   32'(cQ),   32'h5E);
      check("stray vQ",   32'(vQ),   32'h5D);

      // Asynchronous reset in BUSY
      cReq = 1'b1; cA = 18'h00500; cWr = 1'b0;
      wait_grant("rst pre", O_CPU, 18'h00500, 1'b0, 8'h00, w);
      #3;
      reset = 1'b1;
      #1;
      check("rst mReq", 32'(mReq), 32'd0);
      check("rst own",  32'(own),  32'd0);
      check("rst acks", 32'({vAck, cAck, lAck}), 32'd0);
      check("rst cQ",   32'(cQ),   32'd0);
      #2;
      reset = 1'b0;
      wait_grant("rst post", O_CPU, 18'h00500, 1'b0, 8'h00, w);
      check("rst post latency", 32'(w), 32'd1);
      check("rst post cQ before", 32'(cQ), 32'd0);
      complete("rst post", O_CPU, 1, 8'h6B, 1'b1);
      check("rst post cQ", 32'(cQ), 32'h6B);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single byte-wide memory controller port between three requesters: video fetch (read-only), CPU, and the ROM/image loader.
- Sits between the cpu/vdu/loader logic and the memory block in zx48, in the clock28 domain.
- Video has fixed top priority. CPU outranks the loader, except that a starvation counter guarantees the loader periodic service.

Parameters:
AW, 18, address width of all requester and memory ports
DW, 8, data width
STARVE, 4, consecutive CPU grants tolerated while loader is pending (1..15)

Ports:
clock  in  1  system clock (clock28)
reset  in  1  asynchronous, active-high reset
vReq  in  1  video read request, level, held until vAck
vA  in  AW  video address
vQ  out  DW  video read data, registered
vAck  out  1  one-cycle pulse: video transfer complete, vQ valid
cReq  in  1  CPU request, level, held until cAck
cWr  in  1  1=write, 0=read
cA  in  AW  CPU address
cD  in  DW  CPU write data
cQ  out  DW  CPU read data, registered
cAck  out  1  one-cycle completion pulse
lReq  in  1  loader request, level, held until lAck
lA  in  AW  loader address
lD  in  DW  loader write data (loader is write-only)
lAck  out  1  one-cycle completion pulse
mReq  out  1  memory request, held until mRdy
mWr  out  1  memory write enable
mA  out  AW  memory address
mD  out  DW  memory write data
mQ  in  DW  memory read data, valid in the mRdy cycle
mRdy  in  1  one-cycle completion from memory controller
own  out  2  current owner: 0 none, 1 video, 2 cpu, 3 loader

Behaviour:
- Reset (async, active-high): state IDLE; mReq, mWr, vAck, cAck, lAck = 0; mA, mD, vQ, cQ = 0; own = 0; starvation counter = 0.
- FSM states:
  - IDLE: if any req is high, pick the winner. Latch its address, data and write flag into mA/mD/mWr, set mReq=1, set own, go to BUSY. If no req, stay in IDLE.
  - BUSY: hold mReq/mA/mD/mWr stable. On mRdy: mReq=0; for a read, latch mQ into the owner's Q register; go to DONE.
  - DONE: pulse the owner's ack for exactly this one cycle, own=0, go to IDLE. No arbitration in DONE. This guarantees the requester drops its req before the next IDLE sample.
- Priority in IDLE:
  - vReq wins.
  - Otherwise, if cReq and lReq are both high and the counter equals STARVE, the loader wins.
  - Otherwise cReq wins; otherwise lReq wins.
- Starvation counter (4-bit):
  - Increments on each CPU grant made while lReq=1, saturating at STARVE.
  - Cleared on a loader grant, or in any cycle with lReq=0.
  - Video grants leave it unchanged.
- Latency:
  - Request seen high in IDLE → mReq high next cycle.
  - mRdy → ack one cycle later.
  - Minimum transaction: 3 cycles from grant to the next possible grant (mRdy in the first BUSY cycle).
- Q registers: cQ and vQ update only on reads completed for that owner, otherwise hold. lAck never modifies vQ/cQ.
- Req dropped mid-transaction: the transaction still completes and the ack still pulses. No abort.
- mRdy outside BUSY: ignored.
- Simultaneous requests: exactly one grant per IDLE visit; losers keep req high and are re-evaluated in the next IDLE.
- Reset mid-transaction: immediate return to the reset state. mReq drops asynchronously and no ack is issued; the memory controller shares the same reset.
- Video read-only: the arbiter forces mWr=0 for video grants.

Test Plan:
- CPU read alone: cReq=1, cA=0x04000, mRdy returned 2 cycles after mReq with mQ=0xA5 → mA=0x04000, mWr=0, cQ=0xA5, cAck single pulse 1 cycle after mRdy, own=2 during BUSY.
- Simultaneous vReq/cReq/lReq in IDLE → grant order video, cpu, loader; each ack pulses once; DONE cycle separates grants; mWr=1 with mD=lD only for the loader.
- Starvation with STARVE=4: cReq held continuously (re-asserted after each ack), lReq=1, lA=0x00010, lD=0x3C → exactly 4 CPU grants, then a loader grant writing 0x3C to 0x00010, counter back to 0, then CPU resumes.
- Video pre-emption of the pending queue: cReq and lReq pending; vReq rises during a CPU BUSY → after the CPU DONE, video is granted before the loader, and the counter does not change on the video grant.
- Requester abort: cReq deasserted in BUSY with mRdy 3 cycles later → transaction completes, cAck still pulses, next IDLE grants nothing.
- Async reset asserted in BUSY → mReq, own, and all acks go to 0 without waiting for a clock edge; after release, a new request is granted normally and cQ reads 0 until updated.
